apb4_mem_slave: RTL and testbench

//  Parametrised APB4 memory-mapped slave (successor of the fixed 256x32 APB slave).

---
 rtl/apb4_mem_slave.sv | 144 ++++++++++++++
 tb/tb_apb4_mem_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : apb4_mem_slave                                             |
// | Description : Parametrised APB4 memory-mapped slave. Word-addressed RAM  |
// |               with byte-lane writes (pstrb), configurable wait states,   |
// |               an optional read-only upper region, decoded error          |
// |               responses and a saturating error counter.                  |
// | Ports       : pclk/presetn  clock, async active-low reset                |
// |               psel/penable/pwrite/paddr/pwdata/pstrb   APB request       |
// |               prdata/pready/pslverr                    APB response      |
// |               err_cnt       saturating count of error responses          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module apb4_mem_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1,
   parameter int RO_BASE     = DEPTH
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic [7:0]              err_cnt
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(NBYTES);
   localparam int IDX_W  = ADDR_WIDTH - LSB;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                  state;
   logic [3:0]              wait_cnt;
   logic [MEM_AW-1:0]       idx_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NBYTES-1:0]       strb_q;
   logic                    err_q;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Address decode on the live bus; only sampled in the setup cycle.
   logic [IDX_W-1:0]        idx;
   logic [31:0]             idx_ext;
   logic                    out_of_range;
   logic                    in_ro;
   logic                    decode_err;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    commit;

   assign idx          = paddr[ADDR_WIDTH-1:LSB];
   assign idx_ext      = 32'(idx);
   assign out_of_range = (idx_ext >= 32'(DEPTH));
   assign in_ro        = (idx_ext >= 32'(RO_BASE));
   assign decode_err   = out_of_range || (pwrite && in_ro);
   // Truncated index may alias when out of range; the mux below discards it then.
   assign rd_word      = mem[idx[MEM_AW-1:0]];

   // Byte-offset bits within a word carry no meaning for this slave.
   generate
      if (LSB > 0) begin : g_lsb_unused
         logic unused_lsb;
         assign unused_lsb = ^paddr[(LSB > 0 ? LSB-1 : 0):0];
      end
   endgenerate

   assign pready  = (state == ST_ACCESS) && penable && (wait_cnt == 4'(WAIT_STATES));
   assign pslverr = pready && err_q;
   assign commit  = pready && psel && write_q && !err_q;

   // Transfer control FSM with all captured request state.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         err_q    <= 1'b0;
         prdata   <= '0;
         err_cnt  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (psel && !penable) begin
                  idx_q    <= idx[MEM_AW-1:0];
                  write_q  <= pwrite;
                  wdata_q  <= pwdata;
                  strb_q   <= pstrb;
                  err_q    <= decode_err;
                  prdata   <= (!pwrite && !decode_err) ? rd_word : '0;
                  wait_cnt <= 4'd0;
                  state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!psel) begin
                  // Bus abort: abandon the transfer without side effects.
                  state <= ST_IDLE;
               end else if (pready) begin
                  if (err_q && (err_cnt != 8'hFF)) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
                  state <= ST_IDLE;
               end else if (wait_cnt < 4'(WAIT_STATES)) begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage array, cleared by reset; byte lanes written per captured strobe.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem[w] <= '0;
         end
      end else if (commit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (strb_q[b]) begin
               mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb4_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_apb4_mem_slave                                          |
// | Description : Directed self-checking bench for apb4_mem_slave. Instance  |
// |               a uses 2 wait states with an RO region, instance b uses 0  |
// |               wait states for back-to-back and saturation checks.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_apb4_mem_slave;

   logic        pclk;
   logic        presetn;

   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [7:0]  err_cnt;

   logic        b_psel, b_penable, b_pwrite;
   logic [11:0] b_paddr;
   logic [31:0] b_pwdata;
   logic [3:0]  b_pstrb;
   logic [31:0] b_prdata;
   logic        b_pready, b_pslverr;
   logic [7:0]  b_err_cnt;

   int tests = 0;
   int fails = 0;

   apb4_mem_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(2), .RO_BASE(48)
   ) dut_a (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .err_cnt(err_cnt)
   );

   apb4_mem_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(0), .RO_BASE(48)
   ) dut_b (
      .pclk(pclk), .presetn(presetn), .psel(b_psel), .penable(b_penable),
      .pwrite(b_pwrite), .paddr(b_paddr), .pwdata(b_pwdata), .pstrb(b_pstrb),
      .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr), .err_cnt(b_err_cnt)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Full transfer on instance a; nacc = ACCESS cycles up to and including pready.
   task automatic a_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [31:0] rd,
                         output logic err, output int nacc);
      logic done;
      rd = '0; err = 1'b0; nacc = 0; done = 1'b0;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      while (!done) begin
         nacc++;
         @(negedge pclk);
         if (pready) begin
            rd = prdata; err = pslverr; done = 1'b1;
         end else if (nacc >= 20) begin
            check("a_timeout", 32'(pready), 32'd1);
            done = 1'b1;
         end else begin
            @(posedge pclk); #1;
         end
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic b_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [31:0] rd,
                         output logic err, output int nacc);
      logic done;
      rd = '0; err = 1'b0; nacc = 0; done = 1'b0;
      @(posedge pclk); #1;
      b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr; b_paddr = addr; b_pwdata = data; b_pstrb = strb;
      @(posedge pclk); #1;
      b_penable = 1'b1;
      while (!done) begin
         nacc++;
         @(negedge pclk);
         if (b_pready) begin
            rd = b_prdata; err = b_pslverr; done = 1'b1;
         end else if (nacc >= 20) begin
            check("b_timeout", 32'(b_pready), 32'd1);
            done = 1'b1;
         end else begin
            @(posedge pclk); #1;
         end
      end
      @(posedge pclk); #1;
      b_psel = 1'b0; b_penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          nacc;

      presetn = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = '0; b_pwdata = '0; b_pstrb = '0;
      repeat (3) @(negedge pclk);
      check("rst_pready",  32'(pready),  32'd0);
      check("rst_pslverr", 32'(pslverr), 32'd0);
      check("rst_prdata",  prdata,       32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      presetn = 1'b1;

      // Full-word write then read, with wait-state latency
      a_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, nacc);
      check("t1_wr_lat", 32'(nacc), 32'd3);
      check("t1_wr_err", 32'(err),  32'd0);
      a_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, err, nacc);
      check("t1_rd_lat",  32'(nacc), 32'd3);
      check("t1_rd_data", rd,        32'hDEADBEEF);
      check("t1_rd_err",  32'(err),  32'd0);

      // Partial byte-lane write
      a_xfer(1'b1, 12'h010, 32'h11223344, 4'b0101, rd, err, nacc);
      a_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, err, nacc);
      check("t2_rd_data", rd, 32'hDE22BE44);

      // Zero-strobe write is OKAY and leaves data alone; low address bits ignored
      a_xfer(1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, rd, err, nacc);
      check("strb0_err", 32'(err), 32'd0);
      a_xfer(1'b0, 12'h013, 32'h0, 4'h0, rd, err, nacc);
      check("strb0_rd_data", rd, 32'hDE22BE44);

      // Out-of-range accesses
      a_xfer(1'b1, 12'h100, 32'hCAFEF00D, 4'hF, rd, err, nacc);
      check("t3_wr_err", 32'(err), 32'd1);
      a_xfer(1'b0, 12'h100, 32'h0, 4'h0, rd, err, nacc);
      check("t3_rd_err",  32'(err), 32'd1);
      check("t3_rd_data", rd,       32'd0);
      @(negedge pclk);
      check("t3_err_cnt", 32'(err_cnt), 32'd2);

      // Read-only region
      a_xfer(1'b0, 12'h0C0, 32'h0, 4'h0, rd, err, nacc);
      check("t4_rd_err",  32'(err), 32'd0);
      check("t4_rd_data", rd,       32'd0);
      a_xfer(1'b1, 12'h0C0, 32'hFFFFFFFF, 4'hF, rd, err, nacc);
      check("t4_wr_err", 32'(err), 32'd1);
      a_xfer(1'b0, 12'h0C0, 32'h0, 4'h0, rd, err, nacc);
      check("t4_reread", rd, 32'd0);
      @(negedge pclk);
      check("t4_err_cnt", 32'(err_cnt), 32'd3);

      // Bus abort after one ACCESS cycle
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'hAAAA5555; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("t5_no_ready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      a_xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, err, nacc);
      check("t5_rd_lat",  32'(nacc), 32'd3);
      check("t5_rd_data", rd,        32'd0);
      check("t5_err_cnt", 32'(err_cnt), 32'd3);

      // Back-to-back zero-wait writes on instance b: 2 cycles each
      @(posedge pclk); #1;
      b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 12'h004; b_pwdata = 32'h12345678; b_pstrb = 4'hF;
      @(negedge pclk);
      check("b2b_setup_a", 32'(b_pready), 32'd0);
      @(posedge pclk); #1;
      b_penable = 1'b1;
      @(negedge pclk);
      check("b2b_ready_a", 32'(b_pready), 32'd1);
      @(posedge pclk); #1;
      b_penable = 1'b0; b_paddr = 12'h008; b_pwdata = 32'h9ABCDEF0;
      @(negedge pclk);
      check("b2b_setup_b", 32'(b_pready), 32'd0);
      @(posedge pclk); #1;
      b_penable = 1'b1;
      @(negedge pclk);
      check("b2b_ready_b", 32'(b_pready), 32'd1);
      @(posedge pclk); #1;
      b_psel = 1'b0; b_penable = 1'b0;
      b_xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, err, nacc);
      check("b2b_rd_lat",  32'(nacc), 32'd1);
      check("b2b_rd_a",    rd,        32'h12345678);
      b_xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, err, nacc);
      check("b2b_rd_b",    rd,        32'h9ABCDEF0);

      // Reset during ACCESS of a write on instance a
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      presetn = 1'b0;
      #1;
      check("t6_pready",  32'(pready),  32'd0);
      check("t6_err_cnt", 32'(err_cnt), 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      a_xfer(1'b0, 12'h030, 32'h0, 4'h0, rd, err, nacc);
      check("t6_rd_data", rd, 32'd0);
      a_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, err, nacc);
      check("t6_mem_clr", rd, 32'd0);

      // Error counter saturation on instance b
      for (int i = 0; i < 260; i++) begin
         b_xfer(1'b1, 12'h100, 32'h0, 4'hF, rd, err, nacc);
      end
      @(negedge pclk);
      check("sat_err_cnt", 32'(b_err_cnt), 32'h000000FF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
